// File: rtl/day3_rucksack_scorer.sv
// Day 3 rucksack scorer: streams newline-delimited ASCII from a 1-cycle ROM and sums common-item priorities.
// Optional debug ports are added when DAY3_DEBUG_EN is defined.
module day3_rucksack_scorer #(
  parameter int ADDR_W     = 12,
  parameter int MAX_LINE   = 64,
  parameter int GROUP_SIZE = 3,
  parameter int SUM_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done,
  output logic [15:0]       line_count,
  output logic              err
`ifdef DAY3_DEBUG_EN
  ,
  output logic [7:0]        debug_rom_out,
  output logic [63:0]       debug_comparator,
  output logic [63:0]       debug_half1,
  output logic [63:0]       debug_half2
`endif
);

  localparam int LEN_W  = $clog2(MAX_LINE + 2);
  localparam int GCNT_W = $clog2(GROUP_SIZE + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LINE);
  localparam logic [LEN_W-1:0]  LEN_SAT   = LEN_W'(MAX_LINE + 1);

  typedef enum logic [2:0] {IDLE, SCAN, HALF1, HALF2, GROUP, SCORE, FINISH} state_e;

  function automatic logic [5:0] itemPrio(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return 6'(b - 8'h60);
    else if (b >= 8'h41 && b <= 8'h5A) return 6'(b - 8'h26);
    else return 6'd0;
  endfunction

  function automatic logic [51:0] itemBit(input logic [7:0] b);
    logic [5:0] p;
    p = itemPrio(b);
    if (p == 6'd0) return '0;
    else return 52'd1 << (p - 6'd1);
  endfunction

  function automatic logic [5:0] lowestPrio(input logic [51:0] m);
    logic [5:0] p;
    p = 6'd0;
    for (int i = 51; i >= 0; i--) begin
      if (m[i]) p = 6'(i + 1);
    end
    return p;
  endfunction

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d, nextBase_q, nextBase_d, rdAddr_q;
  logic                valid_q, valid_d, eoi_q, eoi_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [51:0]         maskA_q, maskA_d, maskB_q, maskB_d;
  logic [51:0]         lineMask_q, lineMask_d, groupAcc_q, groupAcc_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [15:0]         lineCount_q, lineCount_d;
  logic                err_q, err_d, done_q, done_d;

  logic [ADDR_W-1:0]   addrNext;
  logic [51:0]         byteBit, comparator;
  logic                isNul, isNl, atEnd, lineEnd, inputEnd;
  logic [LEN_W-1:0]    lenNext, halfA, halfB;
  logic [5:0]          scorePrio;

  // rdAddr_q is the address of the byte currently on rom_data; the address never wraps past the last location
  assign addrNext   = (addr_q == LAST_ADDR) ? addr_q : addr_q + ADDR_W'(1);
  assign byteBit    = itemBit(rom_data);
  assign isNul      = (rom_data == 8'h00);
  assign isNl       = (rom_data == 8'h0A);
  assign atEnd      = (rdAddr_q == LAST_ADDR);
  assign lineEnd    = isNul | isNl | atEnd;
  assign inputEnd   = isNul | atEnd;
  assign lenNext    = (isNul || isNl) ? len_q : ((len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1));
  assign halfA      = len_q >> 1;
  assign halfB      = len_q - halfA;
  assign comparator = mode_q ? groupAcc_q : (maskA_q & maskB_q);
  assign scorePrio  = lowestPrio(comparator);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    base_d      = base_q;
    nextBase_d  = nextBase_q;
    valid_d     = valid_q;
    eoi_d       = eoi_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    maskA_d     = maskA_q;
    maskB_d     = maskB_q;
    lineMask_d  = lineMask_q;
    groupAcc_d  = groupAcc_q;
    gcnt_d      = gcnt_q;
    sum_d       = sum_q;
    lineCount_d = lineCount_q;
    err_d       = err_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          sum_d       = '0;
          lineCount_d = '0;
          err_d       = 1'b0;
          done_d      = 1'b0;
          base_d      = '0;
          addr_d      = '0;
          valid_d     = 1'b0;
          eoi_d       = 1'b0;
          len_d       = '0;
          cnt_d       = '0;
          maskA_d     = '0;
          maskB_d     = '0;
          lineMask_d  = '0;
          gcnt_d      = '0;
          state_d     = mode ? GROUP : SCAN;
        end
      end

      SCAN: begin
        addr_d  = addrNext;
        valid_d = 1'b1;
        if (valid_q) begin
          len_d = lenNext;
          if (lineEnd) begin
            eoi_d      = inputEnd;
            nextBase_d = rdAddr_q + ADDR_W'(1);
            if (lenNext == '0 || lenNext > LEN_MAX) begin
              if (lenNext > LEN_MAX) err_d = 1'b1;
              if (inputEnd) begin
                state_d = FINISH;
              end else begin
                base_d  = rdAddr_q + ADDR_W'(1);
                addr_d  = rdAddr_q + ADDR_W'(1);
                valid_d = 1'b0;
                len_d   = '0;
              end
            end else begin
              addr_d  = base_q;
              valid_d = 1'b0;
              cnt_d   = '0;
              state_d = ((lenNext >> 1) == '0) ? HALF2 : HALF1;
            end
          end
        end
      end

      // HALF1 hands over to HALF2 without a bubble: the next address is already in flight
      HALF1: begin
        addr_d  = addrNext;
        valid_d = 1'b1;
        if (valid_q) begin
          maskA_d = maskA_q | byteBit;
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == halfA) begin
            cnt_d   = '0;
            state_d = HALF2;
          end
        end
      end

      HALF2: begin
        addr_d  = addrNext;
        valid_d = 1'b1;
        if (valid_q) begin
          maskB_d = maskB_q | byteBit;
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == halfB) begin
            if (len_q[0]) err_d = 1'b1;
            state_d = SCORE;
          end
        end
      end

      GROUP: begin
        addr_d  = addrNext;
        valid_d = 1'b1;
        if (valid_q) begin
          len_d      = lenNext;
          lineMask_d = lineMask_q | byteBit;
          if (lineEnd) begin
            len_d      = '0;
            lineMask_d = '0;
            if (lenNext != '0) begin
              groupAcc_d = ((gcnt_q == '0) ? '1 : groupAcc_q) & (lineMask_q | byteBit);
              if (gcnt_q == GCNT_W'(GROUP_SIZE - 1)) begin
                gcnt_d     = '0;
                eoi_d      = inputEnd;
                nextBase_d = rdAddr_q + ADDR_W'(1);
                state_d    = SCORE;
              end else begin
                gcnt_d = gcnt_q + GCNT_W'(1);
                if (inputEnd) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
                end
              end
            end else if (inputEnd) begin
              if (gcnt_q != '0) err_d = 1'b1;
              state_d = FINISH;
            end
          end
        end
      end

      SCORE: begin
        sum_d       = sum_q + SUM_W'(scorePrio);
        lineCount_d = lineCount_q + 16'd1;
        if (comparator == '0) err_d = 1'b1;
        maskA_d    = '0;
        maskB_d    = '0;
        lineMask_d = '0;
        len_d      = '0;
        cnt_d      = '0;
        valid_d    = 1'b0;
        if (eoi_q) begin
          state_d = FINISH;
        end else begin
          base_d  = nextBase_q;
          addr_d  = nextBase_q;
          state_d = mode_q ? GROUP : SCAN;
        end
      end

      FINISH: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (state_d == FINISH) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      nextBase_q  <= '0;
      rdAddr_q    <= '0;
      valid_q     <= 1'b0;
      eoi_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      maskA_q     <= '0;
      maskB_q     <= '0;
      lineMask_q  <= '0;
      groupAcc_q  <= '0;
      gcnt_q      <= '0;
      sum_q       <= '0;
      lineCount_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      nextBase_q  <= nextBase_d;
      rdAddr_q    <= addr_q;
      valid_q     <= valid_d;
      eoi_q       <= eoi_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      maskA_q     <= maskA_d;
      maskB_q     <= maskB_d;
      lineMask_q  <= lineMask_d;
      groupAcc_q  <= groupAcc_d;
      gcnt_q      <= gcnt_d;
      sum_q       <= sum_d;
      lineCount_q <= lineCount_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign sum        = sum_q;
  assign line_count = lineCount_q;
  assign err        = err_q;
  assign done       = done_q;
  assign busy       = (state_q == SCAN) || (state_q == HALF1) || (state_q == HALF2) ||
                      (state_q == GROUP) || (state_q == SCORE);

`ifdef DAY3_DEBUG_EN
  logic [7:0] debugRom_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) debugRom_q <= '0;
    else        debugRom_q <= rom_data;
  end

  assign debug_rom_out    = debugRom_q;
  assign debug_comparator = {12'd0, comparator};
  assign debug_half1      = {12'd0, (mode_q ? groupAcc_q : maskA_q)};
  assign debug_half2      = {12'd0, (mode_q ? lineMask_q : maskB_q)};
`endif

endmodule

// File: tb/tb_day3_rucksack_scorer.sv
// Self-checking bench for day3_rucksack_scorer: directed puzzle cases plus random ROM images
// scored by a priority-counting reference model.
module tb_day3_rucksack_scorer;

  localparam int ADDR_W      = 12;
  localparam int MAX_LINE    = 64;
  localparam int GROUP_SIZE  = 3;
  localparam int SUM_W       = 32;
  localparam int ROM_SIZE    = 1 << ADDR_W;
  localparam int CYCLE_LIMIT = 20000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [SUM_W-1:0]  sum;
  logic              busy;
  logic              done;
  logic [15:0]       line_count;
  logic              err;
`ifdef DAY3_DEBUG_EN
  logic [7:0]        debugRomOut;
  logic [63:0]       debugComparator, debugHalf1, debugHalf2;
`endif

  day3_rucksack_scorer #(
    .ADDR_W(ADDR_W), .MAX_LINE(MAX_LINE), .GROUP_SIZE(GROUP_SIZE), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .rom_addr(rom_addr), .rom_data(rom_data), .sum(sum), .busy(busy),
    .done(done), .line_count(line_count), .err(err)
`ifdef DAY3_DEBUG_EN
    , .debug_rom_out(debugRomOut), .debug_comparator(debugComparator),
    .debug_half1(debugHalf1), .debug_half2(debugHalf2)
`endif
  );

  logic [7:0] rom [0:ROM_SIZE-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  int          vectorCount = 0;
  int          failCount   = 0;
  int          wrPtr;
  string       alpha = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ";
  logic [31:0] expSum;
  int          expLines;
  bit          expErr;
  int          seen [53];
  int          gcnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
    wrPtr = 0;
  endtask

  task automatic putString(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rom[wrPtr] = s[i];
      wrPtr++;
    end
  endtask

  function automatic logic [7:0] pickLetter(input int off);
    return alpha[off + $urandom_range(0, 5)];
  endfunction

  function automatic int benchPrio(input logic [7:0] b);
    if (b >= "a" && b <= "z") return int'(b) - 96;
    if (b >= "A" && b <= "Z") return int'(b) - 38;
    return 0;
  endfunction

  function automatic bit lineHas(input int s, input int e, input int p);
    for (int k = s; k < e; k++) if (benchPrio(rom[k]) == p) return 1'b1;
    return 1'b0;
  endfunction

  // Model works per priority value: the lowest priority present in every part is the common item
  task automatic modelLine(input bit md, input int s, input int e);
    int  len, h;
    bit  found;
    len = e - s;
    if (len == 0) return;
    found = 1'b0;
    if (!md) begin
      if (len > MAX_LINE) begin
        expErr = 1'b1;
        return;
      end
      if (len % 2 != 0) expErr = 1'b1;
      h = len / 2;
      for (int p = 1; p <= 52; p++) begin
        if (!found && lineHas(s, s + h, p) && lineHas(s + h, e, p)) begin
          expSum = expSum + 32'(p);
          found  = 1'b1;
        end
      end
      if (!found) expErr = 1'b1;
      expLines++;
    end else begin
      for (int p = 1; p <= 52; p++) if (lineHas(s, e, p)) seen[p]++;
      gcnt++;
      if (gcnt == GROUP_SIZE) begin
        for (int p = 1; p <= 52; p++) begin
          if (!found && seen[p] == GROUP_SIZE) begin
            expSum = expSum + 32'(p);
            found  = 1'b1;
          end
        end
        if (!found) expErr = 1'b1;
        expLines++;
        for (int p = 0; p < 53; p++) seen[p] = 0;
        gcnt = 0;
      end
    end
  endtask

  task automatic runModel(input bit md);
    int s, e;
    expSum = 0;
    expLines = 0;
    expErr = 1'b0;
    gcnt = 0;
    for (int p = 0; p < 53; p++) seen[p] = 0;
    s = 0;
    e = ROM_SIZE;
    for (int i = 0; i < ROM_SIZE; i++) begin
      if (rom[i] == 8'h00) begin
        e = i;
        break;
      end
      if (rom[i] == 8'h0A) begin
        modelLine(md, s, i);
        s = i + 1;
      end
    end
    modelLine(md, s, e);
    if (md && gcnt != 0) expErr = 1'b1;
  endtask

  task automatic applyStimulus(input bit md, input string tag, input logic [31:0] wantSum,
                               input int wantLines, input bit wantErr);
    int n;
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
    checkOutput({tag, ".busyAfterStart"}, 64'(busy), 64'd1);
    checkOutput({tag, ".doneAfterStart"}, 64'(done), 64'd0);
    n = 0;
    while (!done && n < CYCLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".doneInTime"}, 64'(done), 64'd1);
    if (!done) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    checkOutput({tag, ".sum"}, 64'(sum), 64'(wantSum));
    checkOutput({tag, ".line_count"}, 64'(line_count), 64'(wantLines));
    checkOutput({tag, ".err"}, 64'(err), 64'(wantErr));
    checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({tag, ".doneHeld"}, 64'(done), 64'd1);
  endtask

  initial begin
    string example, longLine;
    int    n, off, lineLen, cnt, nLines, kind, len;

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    clearRom();
    repeat (3) @(negedge clk);
    checkOutput("reset.rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("reset.sum", 64'(sum), 64'd0);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.line_count", 64'(line_count), 64'd0);
    checkOutput("reset.err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed puzzle cases");
    clearRom();
    putString("vJrwpWtwJgWrhcsFMMfFFhFp\n");
    applyStimulus(1'b0, "oneLine", 32'd16, 1, 1'b0);

    example = {"vJrwpWtwJgWrhcsFMMfFFhFp\n", "jqHRNqRjqzjGDLGLrsFMfFZSrLrFZsSL\n",
               "PmmdzqPrVvPwwTWBwg\n", "wMqvLMZHhHMvwLHjbvcjnnSBnvTQFn\n",
               "ttgJtRGJQctTZtZT\n", "CrZsJsPPZsGzwwsLwLmpwMDw\n"};
    clearRom();
    putString(example);
    applyStimulus(1'b0, "example.mode0", 32'd157, 6, 1'b0);
    applyStimulus(1'b1, "example.mode1", 32'd70, 2, 1'b0);

    clearRom();
    putString("abca\n\nabc\n");
    applyStimulus(1'b0, "oddAndEmpty", 32'd1, 2, 1'b1);

    longLine = "";
    for (int i = 0; i < MAX_LINE + 1; i++) longLine = {longLine, "b"};
    clearRom();
    putString({longLine, "\naa\n"});
    applyStimulus(1'b0, "longLine", 32'd1, 1, 1'b1);

    clearRom();
    putString("abc\nade\nafg\nxyz\n");
    applyStimulus(1'b1, "partialGroup", 32'd1, 1, 1'b1);

    $display("[TB] reset during a run");
    clearRom();
    putString(example);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (line_count == 16'd0 && n < CYCLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midReset.firstLineScored", 64'(line_count), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("midReset.sum", 64'(sum), 64'd0);
    checkOutput("midReset.busy", 64'(busy), 64'd0);
    checkOutput("midReset.done", 64'(done), 64'd0);
    checkOutput("midReset.line_count", 64'(line_count), 64'd0);
    checkOutput("midReset.err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, "afterReset", 32'd157, 6, 1'b0);

    $display("[TB] random ROM images");
    for (int iter = 0; iter < 12; iter++) begin
      clearRom();
      off    = $urandom_range(0, 46);
      nLines = $urandom_range(1, 10);
      for (int l = 0; l < nLines; l++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0)      len = 0;
        else if (kind == 1) len = $urandom_range(1, 9);
        else if (kind == 2) len = $urandom_range(MAX_LINE - 4, MAX_LINE + 6);
        else                len = 2 * $urandom_range(1, 15);
        for (int c = 0; c < len; c++) begin
          rom[wrPtr] = pickLetter(off);
          wrPtr++;
        end
        if (l != nLines - 1 || $urandom_range(0, 1) == 1) begin
          rom[wrPtr] = 8'h0A;
          wrPtr++;
        end
      end
      for (int m = 0; m < 2; m++) begin
        runModel(m[0]);
        applyStimulus(m[0], $sformatf("rand%0d.mode%0d", iter, m), expSum, expLines, expErr);
      end
    end

    $display("[TB] ROM filled to the last address");
    clearRom();
    off     = $urandom_range(0, 46);
    lineLen = 2 * $urandom_range(1, 10);
    cnt     = 0;
    for (int i = 0; i < ROM_SIZE; i++) begin
      if (cnt == lineLen) begin
        rom[i]  = 8'h0A;
        cnt     = 0;
        lineLen = 2 * $urandom_range(1, 10);
      end else begin
        rom[i] = pickLetter(off);
        cnt++;
      end
    end
    for (int m = 0; m < 2; m++) begin
      runModel(m[0]);
      applyStimulus(m[0], $sformatf("fullRom.mode%0d", m), expSum, expLines, expErr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
